// File: rtl/keypad_matrix_responder.sv
// keypad_matrix_responder
// Stands in for a 4x4 matrix keypad. It watches the active-low row lines driven
// by a keyboard scanner and answers on the active-low column lines for every
// pressed key. Press and release commands arrive over a valid/ready handshake.
// Each real contact change first goes through a pseudo-random bounce window.
//
// Ports
//   clk_50M    in   1   system clock, rising edge
//   RST        in   1   synchronous reset, active-high
//   row        in   4   scanner row drive, active-low (row[r]=0 selects row r)
//   col        out  4   registered column return, active-low, idles at 4'hF
//   cmd_valid  in   1   command present
//   cmd_ready  out  1   responder can accept a command (IDLE only)
//   cmd_key    in   4   key index k = 4*r + c
//   cmd_press  in   1   1 = press key k, 0 = release key k
//   key_state  out  16  settled contact state per key, 1 = pressed
//   busy       out  1   bounce window in progress
module keypad_matrix_responder #(
    parameter int          BOUNCE_CYCLES = 1000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk_50M,
    input  logic        RST,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic        cmd_press,
    output logic [15:0] key_state,
    output logic        busy
);

    // Counter holds BOUNCE_CYCLES-1 down to 0, so the window lasts BOUNCE_CYCLES cycles.
    localparam int CNT_W = (BOUNCE_CYCLES > 2) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
    localparam logic BOUNCE_EN = (BOUNCE_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        tgt_q, tgt_d;
    logic              val_q, val_d;
    logic [15:0]       key_state_q, key_state_d;
    logic [3:0]        col_q, col_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [15:0]       eff_s;

    // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10), shifting left.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb};
    endfunction

    // State register: every flop of the block, synchronous reset has priority.
    always_ff @(posedge clk_50M) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tgt_q       <= 4'd0;
            val_q       <= 1'b0;
            key_state_q <= 16'h0000;
            col_q       <= 4'hF;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            val_q       <= val_d;
            key_state_q <= key_state_d;
            col_q       <= col_d;
            lfsr_q      <= lfsr_d;
        end
    end

    // Next-state logic of the command FSM and the settled key state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        val_d       = val_q;
        key_state_d = key_state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_d = cmd_key;
                    val_d = cmd_press;
                    // A command that does not change the contact skips the bounce.
                    if (key_state_q[cmd_key] == cmd_press) begin
                        state_d = ST_DONE;
                    end else if (!BOUNCE_EN) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BOUNCE;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BOUNCE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                key_state_d[tgt_q] = val_q;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // LFSR free-runs every cycle outside reset.
    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    // Effective contacts: the bouncing key follows lfsr[0] while in BOUNCE.
    always_comb begin
        eff_s = key_state_q;
        if (state_q == ST_BOUNCE) begin
            eff_s[tgt_q] = lfsr_q[0];
        end else begin
            eff_s[tgt_q] = key_state_q[tgt_q];
        end
    end

    // Column return: a column is pulled low if any selected row has a closed contact on it.
    always_comb begin
        col_d = 4'hF;
        for (int c = 0; c < 4; c++) begin
            logic hit;
            hit = 1'b0;
            for (int r = 0; r < 4; r++) begin
                hit = hit | (~row[r] & eff_s[4*r + c]);
            end
            col_d[c] = ~hit;
        end
    end

    // Output decode from the FSM state; cmd_ready is held low during a reset cycle.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE:   cmd_ready = ~RST;
            ST_BOUNCE: busy      = 1'b1;
            ST_DONE:   cmd_ready = 1'b0;
            default: begin
                cmd_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    assign col       = col_q;
    assign key_state = key_state_q;

endmodule
